// File: rtl/filter_stream_ctrl.sv
// Stream sequencer for the one-multiplier MAVG/FIR filter stages:
// input FIFO, one filter run per sample, registered result with backpressure.
module filter_stream_ctrl #(
    parameter int BITWIDTH_DATA = 16,
    parameter int FIFO_DEPTH    = 8,
    parameter int TIMEOUT       = 1023
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             EN,
    input  logic [BITWIDTH_DATA-1:0]         S_DATA,
    input  logic                             S_VALID,
    output logic                             S_READY,
    output logic [BITWIDTH_DATA-1:0]         M_DATA,
    output logic                             M_VALID,
    input  logic                             M_READY,
    output logic                             FILT_EN,
    output logic                             FILT_START,
    output logic [BITWIDTH_DATA-1:0]         FILT_DATA,
    input  logic                             FILT_DATA_VALID,
    input  logic [BITWIDTH_DATA-1:0]         FILT_DATA_OUT,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  FIFO_LEVEL,
    output logic                             ERR_TIMEOUT
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH+1);
    localparam int TW = $clog2(TIMEOUT+1);
    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);
    localparam logic [TW-1:0] T_MAX    = TW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t                   state;
    logic [BITWIDTH_DATA-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]            wr_ptr;
    logic [PW-1:0]            rd_ptr;
    logic [TW-1:0]            timer;
    logic                     run;
    logic                     push;
    logic                     pop;
    logic                     expired;

    assign run     = EN && !RST;
    assign FILT_EN = run;
    // Full blocks new input even when a pop happens on the same edge.
    assign S_READY = run && (FIFO_LEVEL != LVL_FULL);
    assign push    = S_VALID && S_READY;
    assign pop     = (state == IDLE) && (FIFO_LEVEL != '0)
                     && (!M_VALID || M_READY);
    assign expired = (timer == T_MAX);

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= S_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (!run) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            FIFO_LEVEL <= '0;
            M_VALID    <= 1'b0;
            M_DATA     <= '0;
            FILT_START <= 1'b0;
            FILT_DATA  <= '0;
            timer      <= '0;
            if (RST) begin
                ERR_TIMEOUT <= 1'b0;
            end
        end else begin
            FILT_START <= 1'b0;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                FIFO_LEVEL <= FIFO_LEVEL + 1'b1;
            end else if (pop && !push) begin
                FIFO_LEVEL <= FIFO_LEVEL - 1'b1;
            end
            // A capture below overrides this clear.
            if (M_VALID && M_READY) begin
                M_VALID <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        FILT_DATA  <= mem[rd_ptr];
                        FILT_START <= 1'b1;
                        timer      <= '0;
                        state      <= START;
                    end
                end
                START: begin
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (expired) begin
                        ERR_TIMEOUT <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                        if (!FILT_DATA_VALID) begin
                            state <= WAIT_DONE;
                        end
                    end
                end
                WAIT_DONE: begin
                    if (expired) begin
                        ERR_TIMEOUT <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                        if (FILT_DATA_VALID) begin
                            M_DATA  <= FILT_DATA_OUT;
                            M_VALID <= 1'b1;
                            state   <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_filter_stream_ctrl.sv
// Directed bench for filter_stream_ctrl with a LENGTH=4 filter model
// (result = 3*x + 0x11, busy for PREP + LENGTH cycles).
module tb_filter_stream_ctrl;

    localparam int W   = 16;
    localparam int LEN = 4;

    logic         CLK = 1'b0;
    logic         RST;
    logic         EN;
    logic [W-1:0] S_DATA;
    logic         S_VALID;
    logic         S_READY;
    logic [W-1:0] M_DATA;
    logic         M_VALID;
    logic         M_READY;
    logic         FILT_EN;
    logic         FILT_START;
    logic [W-1:0] FILT_DATA;
    logic         fdv = 1'b1;
    logic [W-1:0] fdout = '0;
    logic [3:0]   FIFO_LEVEL;
    logic         ERR_TIMEOUT;

    logic         stuck = 1'b0;
    int           fcnt = 0;
    logic [W-1:0] fheld = '0;
    logic [W-1:0] got_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 CLK = ~CLK;

    filter_stream_ctrl #(
        .BITWIDTH_DATA(W),
        .FIFO_DEPTH(8),
        .TIMEOUT(20)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .EN(EN),
        .S_DATA(S_DATA),
        .S_VALID(S_VALID),
        .S_READY(S_READY),
        .M_DATA(M_DATA),
        .M_VALID(M_VALID),
        .M_READY(M_READY),
        .FILT_EN(FILT_EN),
        .FILT_START(FILT_START),
        .FILT_DATA(FILT_DATA),
        .FILT_DATA_VALID(fdv),
        .FILT_DATA_OUT(fdout),
        .FIFO_LEVEL(FIFO_LEVEL),
        .ERR_TIMEOUT(ERR_TIMEOUT)
    );

    function automatic logic [W-1:0] fmod(input logic [W-1:0] x);
        return x * 16'd3 + 16'h0011;
    endfunction

    // Filter model: START seen -> PREP + LEN busy cycles, then DATA_VALID.
    always @(posedge CLK) begin
        if (!FILT_EN) begin
            fdv   <= 1'b1;
            fcnt  <= 0;
            fdout <= '0;
        end else if (fcnt > 0) begin
            fcnt <= fcnt - 1;
            if (fcnt == 1) begin
                fdv   <= 1'b1;
                fdout <= fmod(fheld);
            end
        end else if (FILT_START && !stuck) begin
            fdv   <= 1'b0;
            fcnt  <= LEN + 1;
            fheld <= FILT_DATA;
        end
    end

    always @(negedge CLK) begin
        if (M_VALID && M_READY) begin
            got_q.push_back(M_DATA);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_start(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            tick();
            if (FILT_START) ok = 1'b1;
        end
    endtask

    task automatic wait_results(input int n, input int max);
        for (int i = 0; i < max && got_q.size() < n; i++) begin
            tick();
        end
    endtask

    initial begin
        bit ok;
        bit saw_full;
        int guard;
        int bad;
        logic [W-1:0] held_data;

        RST     = 1'b1;
        EN      = 1'b1;
        S_VALID = 1'b1;
        S_DATA  = 16'hAAAA;
        M_READY = 1'b1;

        // T1 reset
        repeat (3) tick();
        chk("rst_s_ready", S_READY, 0);
        chk("rst_m_valid", M_VALID, 0);
        chk("rst_start", FILT_START, 0);
        chk("rst_level", FIFO_LEVEL, 0);
        chk("rst_err", ERR_TIMEOUT, 0);
        chk("rst_m_data", M_DATA, 0);
        S_VALID = 1'b0;
        RST     = 1'b0;
        tick();

        // T2 single sample: accept edge a, result at a+8
        S_DATA  = 16'h0100;
        S_VALID = 1'b1;
        chk("t2_s_ready", S_READY, 1);
        tick();
        S_VALID = 1'b0;
        chk("t2_level_a", FIFO_LEVEL, 1);
        chk("t2_start_a", FILT_START, 0);
        tick();
        chk("t2_start_a1", FILT_START, 1);
        chk("t2_filt_data", FILT_DATA, 16'h0100);
        chk("t2_level_a1", FIFO_LEVEL, 0);
        tick();
        chk("t2_start_a2", FILT_START, 0);
        repeat (5) tick();
        chk("t2_mvalid_a7", M_VALID, 0);
        tick();
        chk("t2_mvalid_a8", M_VALID, 1);
        chk("t2_mdata", M_DATA, 16'h0311);
        tick();
        chk("t2_mvalid_a9", M_VALID, 0);
        repeat (2) tick();

        // T3 burst of 10 into depth 8
        got_q.delete();
        saw_full = 1'b0;
        for (int i = 0; i < 10; i++) begin
            S_DATA  = 16'h0005 + 16'(i) * 16'h0010;
            S_VALID = 1'b1;
            guard   = 0;
            while (!S_READY && guard < 50) begin
                if (FIFO_LEVEL == 8) saw_full = 1'b1;
                tick();
                guard++;
            end
            tick();
        end
        S_VALID = 1'b0;
        chk("t3_saw_full", saw_full, 1);
        wait_results(10, 300);
        chk("t3_count", got_q.size(), 10);
        bad = 0;
        for (int i = 0; i < got_q.size() && i < 10; i++) begin
            if (got_q[i] !== fmod(16'h0005 + 16'(i) * 16'h0010)) bad++;
        end
        chk("t3_order", bad, 0);
        repeat (3) tick();

        // T4 backpressure
        got_q.delete();
        M_READY = 1'b0;
        S_DATA  = 16'h1234;
        S_VALID = 1'b1;
        tick();
        S_DATA  = 16'h0042;
        tick();
        S_VALID = 1'b0;
        guard = 0;
        while (!M_VALID && guard < 40) begin
            tick();
            guard++;
        end
        chk("t4_mvalid", M_VALID, 1);
        chk("t4_mdata", M_DATA, 16'h36AD);
        held_data = M_DATA;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (!M_VALID || M_DATA !== held_data || FILT_START) bad++;
        end
        chk("t4_held", bad, 0);
        chk("t4_level", FIFO_LEVEL, 1);
        M_READY = 1'b1;
        wait_start(5, ok);
        chk("t4_restart", ok, 1);
        wait_results(2, 40);
        chk("t4_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            chk("t4_r0", got_q[0], 16'h36AD);
            chk("t4_r1", got_q[1], 16'h00D7);
        end
        repeat (3) tick();

        // T5 timeout with a filter that never goes busy
        got_q.delete();
        stuck   = 1'b1;
        S_DATA  = 16'h0055;
        S_VALID = 1'b1;
        tick();
        S_VALID = 1'b0;
        wait_start(5, ok);
        chk("t5_start", ok, 1);
        tick();
        repeat (15) tick();
        chk("t5_err_early", ERR_TIMEOUT, 0);
        guard = 0;
        while (!ERR_TIMEOUT && guard < 15) begin
            tick();
            guard++;
        end
        chk("t5_err", ERR_TIMEOUT, 1);
        chk("t5_no_result", M_VALID, 0);
        stuck   = 1'b0;
        S_DATA  = 16'h0200;
        S_VALID = 1'b1;
        tick();
        S_VALID = 1'b0;
        wait_results(1, 40);
        chk("t5_next_count", got_q.size(), 1);
        if (got_q.size() == 1) chk("t5_next_data", got_q[0], 16'h0611);
        chk("t5_err_sticky", ERR_TIMEOUT, 1);
        repeat (3) tick();

        // T6 flush mid WAIT_DONE with three queued
        got_q.delete();
        for (int i = 0; i < 4; i++) begin
            S_DATA  = 16'h0A00 + 16'(i);
            S_VALID = 1'b1;
            tick();
        end
        S_VALID = 1'b0;
        chk("t6_level3", FIFO_LEVEL, 3);
        chk("t6_busy", fdv, 0);
        EN = 1'b0;
        tick();
        chk("t6_level0", FIFO_LEVEL, 0);
        chk("t6_mvalid", M_VALID, 0);
        chk("t6_filt_en", FILT_EN, 0);
        chk("t6_err", ERR_TIMEOUT, 1);
        chk("t6_s_ready", S_READY, 0);
        EN = 1'b1;
        repeat (12) tick();
        chk("t6_no_out", got_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
